// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-requester round-robin arbiter driving a write-only
// HD44780-style character LCD bus. Each granted byte goes through
// SETUP -> EHIGH -> HOLD -> WAIT before the next request is sampled.
// Optional macro LCD_INIT_SEQ_EN adds a power-on delay and a four-command
// init sequence (0x3C, 0x0C, 0x06, 0x01) ahead of normal operation.
module lcd_bus_arbiter #(
  parameter int E_CYCLES         = 12,
  parameter int WAIT_CYCLES      = 2500,
  parameter int LONG_WAIT_CYCLES = 82000,
  parameter int PWR_CYCLES       = 2000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       RS0,
  input  logic       RS1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  output logic       ACK0,
  output logic       ACK1,
  output logic       READY,
  output logic       BUSY,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam logic [2:0] IDLE  = 3'd2;
  localparam logic [2:0] SETUP = 3'd3;
  localparam logic [2:0] EHIGH = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;
  localparam logic [2:0] WAIT  = 3'd6;

  // One down/up counter serves every timed state, so it must hold the largest delay.
  localparam int MAX_A = (PWR_CYCLES > LONG_WAIT_CYCLES) ? PWR_CYCLES : LONG_WAIT_CYCLES;
  localparam int MAX_B = (MAX_A > E_CYCLES) ? MAX_A : E_CYCLES;
  localparam int MAX_C = (MAX_B > WAIT_CYCLES) ? MAX_B : WAIT_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

`ifdef LCD_INIT_SEQ_EN
  localparam logic [2:0] INIT_PWR  = 3'd0;
  localparam logic [2:0] INIT_CMD  = 3'd1;
  localparam logic [2:0] RST_STATE = INIT_PWR;

  logic [1:0] init_idx;
  logic       ready_q;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h3C;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  assign READY = ready_q;
`else
  localparam logic [2:0] RST_STATE = IDLE;

  assign READY = 1'b1;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;  // 1 = requester 1 was granted last
  logic             long_cmd;

  // Clear and home commands need the long post-write busy time.
  assign long_cmd = !LCD_RS && ((LCD_DATA[7:1] == 7'b0000000) || (LCD_DATA[7:1] == 7'b0000001));
  assign BUSY     = (state != IDLE);
  assign LCD_RW   = 1'b0;

  // Arbitration, bus sequencing and timing counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= RST_STATE;
      cnt        <= '0;
      last_grant <= 1'b1;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      LCD_E      <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DATA   <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
      init_idx   <= 2'd0;
      ready_q    <= 1'b0;
`endif
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      case (state)
`ifdef LCD_INIT_SEQ_EN
        INIT_PWR: begin
          if (cnt == CNT_W'(PWR_CYCLES - 1)) begin
            cnt   <= '0;
            state <= INIT_CMD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_CMD: begin
          LCD_RS   <= 1'b0;
          LCD_DATA <= init_byte(init_idx);
          state    <= SETUP;
        end
`endif
        IDLE: begin
          if (READY && (REQ0 || REQ1)) begin
            // On a tie the requester that did not win last time goes first.
            if (REQ0 && (!REQ1 || last_grant)) begin
              ACK0       <= 1'b1;
              LCD_RS     <= RS0;
              LCD_DATA   <= DATA0;
              last_grant <= 1'b0;
            end else begin
              ACK1       <= 1'b1;
              LCD_RS     <= RS1;
              LCD_DATA   <= DATA1;
              last_grant <= 1'b1;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          LCD_E <= 1'b1;
          cnt   <= CNT_W'(E_CYCLES - 1);
          state <= EHIGH;
        end
        EHIGH: begin
          if (cnt == '0) begin
            LCD_E <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          cnt   <= long_cmd ? CNT_W'(LONG_WAIT_CYCLES - 1) : CNT_W'(WAIT_CYCLES - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
            if (ready_q) begin
              state <= IDLE;
            end else if (init_idx == 2'd3) begin
              ready_q <= 1'b1;
              state   <= IDLE;
            end else begin
              init_idx <= init_idx + 1'b1;
              state    <= INIT_CMD;
            end
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with E=2, WAIT=4, LONG_WAIT=10, PWR=8.
// Inputs are driven and outputs sampled on the falling edge; the sample at
// negedge k shows the state the DUT entered at the preceding rising edge.
module tb_lcd_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, RS0 = 1'b0, RS1 = 1'b0;
  logic [7:0] DATA0 = 8'h00, DATA1 = 8'h00;
  logic       ACK0, ACK1, READY, BUSY, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int n_vec = 0;
  int n_bad = 0;

`ifdef LCD_INIT_SEQ_EN
  localparam logic RDY_RST  = 1'b0;
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic RDY_RST  = 1'b1;
  localparam logic BUSY_RST = 1'b0;
`endif

  always #5 CLK = ~CLK;

  lcd_bus_arbiter #(
    .E_CYCLES(2), .WAIT_CYCLES(4), .LONG_WAIT_CYCLES(10), .PWR_CYCLES(8)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .RS0(RS0), .RS1(RS1),
    .DATA0(DATA0), .DATA1(DATA1),
    .ACK0(ACK0), .ACK1(ACK1), .READY(READY), .BUSY(BUSY),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  // Wait (bounded) for the init sequence to finish; immediate in the default build.
  task automatic wait_ready();
    int k = 0;
    while (!READY && k < 300) begin
      @(negedge CLK);
      k++;
    end
    n_vec++;
    if (READY !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout: READY=%b exp 1", READY);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < 40) begin
      @(negedge CLK);
      k++;
    end
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_timeout: BUSY=%b exp 0", BUSY);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b1; REQ0 = 1'b1;   // request during reset must be ignored
    @(negedge CLK);
    n_vec++;
    if (LCD_E !== 1'b0 || LCD_RS !== 1'b0 || LCD_RW !== 1'b0 || LCD_DATA !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_bus: E=%b RS=%b RW=%b DATA=%h exp 0 0 0 00", LCD_E, LCD_RS, LCD_RW, LCD_DATA);
    end
    n_vec++;
    if (ACK0 !== 1'b0 || ACK1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ack: ACK0=%b ACK1=%b exp 0 0", ACK0, ACK1);
    end
    n_vec++;
    if (BUSY !== BUSY_RST || READY !== RDY_RST) begin
      n_bad++;
      $display("FAIL reset_state: BUSY=%b READY=%b exp %b %b", BUSY, READY, BUSY_RST, RDY_RST);
    end
    RESET = 1'b0; REQ0 = 1'b0;
    wait_ready();
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init();
    logic [7:0] got [4];
    logic [7:0] exp_b [4];
    int   npulse = 0, first_rise = -1, rs_bad = 0, early_ack = 0;
    logic prev_e = 1'b0;
    bit   acked = 1'b0;
    exp_b = '{8'h3C, 8'h0C, 8'h06, 8'h01};
    got   = '{8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h5A;
    for (int i = 0; i < 200 && !acked; i++) begin
      @(negedge CLK);
      if (LCD_E && !prev_e) begin
        if (first_rise < 0) first_rise = i;
        if (npulse < 4) got[npulse] = LCD_DATA;
        if (LCD_RS !== 1'b0) rs_bad++;
        npulse++;
      end
      prev_e = LCD_E;
      if (ACK0 && npulse < 4) early_ack++;
      if (ACK0) acked = 1'b1;
    end
    REQ0 = 1'b0;
    n_vec++;
    if (first_rise !== 9) begin
      n_bad++;
      $display("FAIL init_pwr_delay: first E at %0d exp 9", first_rise);
    end
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (got[j] !== exp_b[j]) begin
        n_bad++;
        $display("FAIL init_byte%0d: got %h exp %h", j, got[j], exp_b[j]);
      end
    end
    n_vec++;
    if (rs_bad != 0 || early_ack != 0 || !acked || npulse != 4) begin
      n_bad++;
      $display("FAIL init_seq: rs_bad=%0d early_ack=%0d acked=%b pulses=%0d exp 0 0 1 4",
               rs_bad, early_ack, acked, npulse);
    end
    wait_idle();
  endtask
`endif

  task automatic test_single();
    int  acks = 0, ack1s = 0, ehi = 0, busy = 0, first_e = -1;
    bit  data_ok = 1'b1;
    @(negedge CLK);
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h41;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        n_vec++;
        if (ACK0 !== 1'b1 || LCD_DATA !== 8'h41 || LCD_RS !== 1'b1 || LCD_E !== 1'b0) begin
          n_bad++;
          $display("FAIL single_grant: ACK0=%b DATA=%h RS=%b E=%b exp 1 41 1 0", ACK0, LCD_DATA, LCD_RS, LCD_E);
        end
        // Requester changes after the grant must not reach the bus.
        REQ0 = 1'b0; RS0 = 1'b0; DATA0 = 8'hFF;
      end
      if (ACK0) acks++;
      if (ACK1) ack1s++;
      if (LCD_E) ehi++;
      if (BUSY) busy++;
      if (LCD_E && first_e < 0) first_e = i;
      if (BUSY && (LCD_DATA !== 8'h41 || LCD_RS !== 1'b1)) data_ok = 1'b0;
    end
    n_vec++;
    if (acks != 1 || ack1s != 0) begin
      n_bad++;
      $display("FAIL single_ack_count: ack0=%0d ack1=%0d exp 1 0", acks, ack1s);
    end
    n_vec++;
    if (ehi != 2 || first_e != 1) begin
      n_bad++;
      $display("FAIL single_e_pulse: high=%0d first=%0d exp 2 1", ehi, first_e);
    end
    n_vec++;
    if (busy != 8 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy: cycles=%0d end=%b exp 8 0", busy, BUSY);
    end
    n_vec++;
    if (!data_ok) begin
      n_bad++;
      $display("FAIL single_data_stable: got changed bus exp 41/RS=1");
    end
  endtask

  // Busy length is 4 + wait; clear/home (RS=0, 0x01..0x03 incl. 0x00) take the long wait.
  task automatic test_wait_select();
    logic [8:0] vec [6];
    int         expw [6];
    vec  = '{{1'b0, 8'h01}, {1'b0, 8'h80}, {1'b0, 8'h02}, {1'b0, 8'h03}, {1'b1, 8'h01}, {1'b0, 8'h04}};
    expw = '{10, 4, 10, 10, 4, 4};
    for (int v = 0; v < 6; v++) begin
      int busy = 0, acks = 0;
      @(negedge CLK);
      REQ1 = 1'b1; RS1 = vec[v][8]; DATA1 = vec[v][7:0];
      for (int i = 0; i < 18; i++) begin
        @(negedge CLK);
        if (i == 0) REQ1 = 1'b0;
        if (BUSY) busy++;
        if (ACK1) acks++;
        if (ACK0) acks += 100;
      end
      n_vec++;
      if (busy - 4 != expw[v] || acks != 1) begin
        n_bad++;
        $display("FAIL wait_sel rs=%b data=%h: wait=%0d acks=%0d exp %0d 1",
                 vec[v][8], vec[v][7:0], busy - 4, acks, expw[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int who [4];
    int at  [4];
    int nack = 0, both = 0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    wait_ready();
    @(negedge CLK);
    REQ0 = 1'b1; REQ1 = 1'b1; RS0 = 1'b1; RS1 = 1'b1; DATA0 = 8'h30; DATA1 = 8'h31;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (ACK0 && ACK1) both++;
      if (ACK0 || ACK1) begin
        if (nack < 4) begin
          who[nack] = ACK1 ? 1 : 0;
          at[nack]  = i;
        end
        nack++;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    n_vec++;
    if (nack != 4 || both != 0) begin
      n_bad++;
      $display("FAIL rr_count: acks=%0d both=%0d exp 4 0", nack, both);
    end
    if (nack >= 4) begin
      for (int j = 0; j < 4; j++) begin
        n_vec++;
        // Pulse-to-pulse period is 9: 8 busy cycles then the IDLE grant cycle.
        if (who[j] != (j % 2) || at[j] != 9 * j) begin
          n_bad++;
          $display("FAIL rr_grant%0d: who=%0d at=%0d exp %0d %0d", j, who[j], at[j], j % 2, 9 * j);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_midop();
    int ehi = 0;
    @(negedge CLK);
    REQ0 = 1'b1; RS0 = 1'b0; DATA0 = 8'h55;
    @(negedge CLK);
    REQ0 = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (LCD_E !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_ehigh: E=%b exp 1", LCD_E);
    end
    RESET = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (LCD_E !== 1'b0 || BUSY !== BUSY_RST || ACK0 !== 1'b0 || ACK1 !== 1'b0 || LCD_DATA !== 8'h00) begin
      n_bad++;
      $display("FAIL midop_abort: E=%b BUSY=%b ACK=%b%b DATA=%h exp 0 %b 00 00",
               LCD_E, BUSY, ACK0, ACK1, LCD_DATA, BUSY_RST);
    end
    RESET = 1'b0;
    wait_ready();
    @(negedge CLK);
    REQ1 = 1'b1; RS1 = 1'b1; DATA1 = 8'h42;
    @(negedge CLK);
    REQ1 = 1'b0;
    n_vec++;
    if (ACK1 !== 1'b1 || ACK0 !== 1'b0 || LCD_DATA !== 8'h42 || LCD_RS !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_resume: ACK1=%b ACK0=%b DATA=%h RS=%b exp 1 0 42 1", ACK1, ACK0, LCD_DATA, LCD_RS);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (LCD_E) ehi++;
    end
    n_vec++;
    if (ehi != 2 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_resume_write: e_high=%0d BUSY=%b exp 2 0", ehi, BUSY);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`endif
    test_single();
    test_wait_select();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
